// File: rtl/instrn_loader.sv
// -----------------------------------------------------------------------------
// instrn_loader
//   Receives a program as a byte stream (big-endian 32-bit words followed by a
//   single XOR checksum byte) and writes each assembled word into the
//   instruction BRAM. The fetch stage is released only after the whole program
//   has been written and the checksum matches.
//
// Parameters
//   ADDR_W     instruction-memory word-address width
//   NOP_WORD   word presented on mem_din whenever mem_we is low
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   load_start  one-cycle pulse starting a load (honoured in IDLE/DONE/ERR only)
//   load_len    number of 32-bit words to load, sampled with load_start
//   byte_valid  byte_data is valid this cycle
//   byte_data   program byte stream
//   byte_ready  loader accepts byte_data this cycle
//   mem_we      BRAM write strobe
//   mem_addr    BRAM word address (low ADDR_W bits of the word counter)
//   mem_din     BRAM write data
//   busy        load in progress
//   done        load finished with a good checksum
//   err         load failed (bad length or bad checksum)
//   fetch_en    fetch stage may run
// -----------------------------------------------------------------------------
module instrn_loader #(
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] NOP_WORD = 32'hFC00_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [11:0]       load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fetch_en
);

  localparam logic [11:0] MAX_LEN = 12'd2048;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t      state, state_next;
  logic [11:0] len;
  logic [11:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  acc;
  logic [31:0] word;

  logic        accept;
  logic        start_ok;
  logic        len_bad;
  logic [11:0] word_cnt_inc;

  assign accept       = byte_valid && byte_ready;
  assign start_ok     = load_start && (state == IDLE || state == DONE || state == ERR);
  assign len_bad      = (load_len == 12'd0) || (load_len > MAX_LEN);
  assign word_cnt_inc = word_cnt + 12'd1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (load_start) state_next = len_bad ? ERR : RECV;
      end
      RECV: begin
        if (accept && byte_cnt == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        // A 12-bit counter lets a 2048-word load reach 2048 without aliasing
        // back to address 0, so the final compare is exact.
        state_next = (word_cnt_inc == len) ? CHECK : RECV;
      end
      CHECK: begin
        if (accept) state_next = (byte_data == acc) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: length latch, counters, word assembly and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      acc      <= '0;
      word     <= '0;
    end else if (start_ok) begin
      len      <= load_len;
      word_cnt <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else begin
      if (state == RECV && accept) begin
        word     <= {word[23:0], byte_data};
        acc      <= acc ^ byte_data;
        byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
      end
      if (state == WRITE) word_cnt <= word_cnt_inc;
    end
  end

  // Outputs are decoded from registered state only.
  assign byte_ready = (state == RECV) || (state == CHECK);
  assign mem_we     = (state == WRITE);
  assign mem_addr   = word_cnt[ADDR_W-1:0];
  assign mem_din    = mem_we ? word : NOP_WORD;
  assign busy       = (state == RECV) || (state == WRITE) || (state == CHECK);
  assign done       = (state == DONE);
  assign fetch_en   = (state == DONE);
  assign err        = (state == ERR);

endmodule

// File: tb/tb_instrn_loader.sv
// -----------------------------------------------------------------------------
// tb_instrn_loader
//   Table-driven bench for instrn_loader: each record describes one program
//   load and its expected outcome; hand-written sequences cover mid-load
//   reset, load_start during RECV and leaving DONE.
// -----------------------------------------------------------------------------
module tb_instrn_loader;

  localparam int          ADDR_W = 11;
  localparam logic [31:0] NOP    = 32'hFC00_0000;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [11:0]       load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              busy;
  logic              done;
  logic              err;
  logic              fetch_en;

  instrn_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fetch_en   (fetch_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: records every write and counts protocol violations.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                viol = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
      if (byte_ready !== 1'b0) viol++;
    end else if (mem_din !== NOP) begin
      viol++;
    end
    if (fetch_en !== done) viol++;
    if (int'(busy) + int'(done) + int'(err) > 1) viol++;
  end

  // Program image model.
  function automatic logic [31:0] word_of(input int i);
    logic [31:0] ii;
    ii = i;
    case (i)
      0:       return 32'h2001_0005;
      1:       return 32'h8C22_0004;
      default: return 32'h3C00_0000 ^ (ii * 32'h0001_3579);
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input int idx);
    logic [31:0] w;
    w = word_of(idx / 4);
    return w[8*(3 - idx % 4) +: 8];
  endfunction

  logic [7:0] acc_m;

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      if (byte_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", ok, 1);
  endtask

  task automatic send_prog(input int from, input int to, input int max_gap);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = byte_of(i);
      acc_m ^= b;
      send_byte(b, (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
  endtask

  // cks_mode: 0 = correct checksum, 1 = literal 0x00, 2 = none sent
  task automatic send_cks(input int cks_mode, input int max_gap);
    int g;
    g = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    if (cks_mode == 0)      send_byte(acc_m, g);
    else if (cks_mode == 1) send_byte(8'h00, g);
  endtask

  task automatic pulse_start(input logic [11:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n0, input int exp_n);
    check({tag, "_write_count"}, wr_addr.size() - n0, exp_n);
    for (int i = 0; i < exp_n && n0 + i < wr_addr.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr[n0+i], i);
      check({tag, "_wr_data"}, wr_data[n0+i], word_of(i));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_mem_we"},     mem_we,     0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_din"},    mem_din,    NOP);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_err"},        err,        0);
    check({tag, "_fetch_en"},   fetch_en,   0);
  endtask

  typedef struct {
    string       name;
    logic [11:0] len;
    int          nwords;
    int          cks_mode;
    int          max_gap;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n0, v0;
    logic [11:0] w;
    n0 = wr_addr.size();
    v0 = viol;
    acc_m = 8'h00;
    pulse_start(v.len);
    if (v.nwords == 0) begin
      check({v.name, "_err_next_cycle"},  err,  1);
      check({v.name, "_busy_next_cycle"}, busy, 0);
    end
    send_prog(0, 4 * v.nwords, v.max_gap);
    send_cks(v.cks_mode, v.max_gap);
    @(negedge clk);
    w = 12'(v.exp_writes);
    check({v.name, "_done"},     done,     v.exp_done);
    check({v.name, "_fetch_en"}, fetch_en, v.exp_done);
    check({v.name, "_err"},      err,      v.exp_err);
    check({v.name, "_busy"},     busy,     0);
    check({v.name, "_mem_addr"}, mem_addr, w[ADDR_W-1:0]);
    check_writes(v.name, n0, v.exp_writes);
    check({v.name, "_violations"}, viol - v0, 0);
  endtask

  vec_t vecs[8];
  int   n0, n1;

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;

    vecs[0] = '{"len2_good",     12'd2,    2,    0, 0, 2,    1'b1, 1'b0};
    vecs[1] = '{"len2_bad_cks",  12'd2,    2,    1, 0, 2,    1'b0, 1'b1};
    vecs[2] = '{"len0",          12'd0,    0,    2, 0, 0,    1'b0, 1'b1};
    vecs[3] = '{"len2049",       12'd2049, 0,    2, 0, 0,    1'b0, 1'b1};
    vecs[4] = '{"len3_nogap",    12'd3,    3,    0, 0, 3,    1'b1, 1'b0};
    vecs[5] = '{"len3_gaps",     12'd3,    3,    0, 4, 3,    1'b1, 1'b0};
    vecs[6] = '{"len1_good",     12'd1,    1,    0, 0, 1,    1'b1, 1'b0};
    vecs[7] = '{"len2048",       12'd2048, 2048, 0, 0, 2048, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Mid-load reset after the 6th byte of a 4-word load.
    acc_m = 8'h00;
    pulse_start(12'd4);
    send_prog(0, 6, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midload_rst");
    n1 = wr_addr.size();
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (8) @(negedge clk);
    byte_valid = 1'b0;
    check("post_rst_no_write", wr_addr.size() - n1, 0);
    check("post_rst_idle_busy", busy, 0);
    run_vec(vecs[6]);

    // load_start during RECV is ignored; original length of 2 is used.
    n0 = wr_addr.size();
    acc_m = 8'h00;
    pulse_start(12'd2);
    send_prog(0, 2, 0);
    pulse_start(12'd1);
    check("recv_start_busy", busy, 1);
    send_prog(2, 8, 0);
    check("recv_start_still_busy", busy, 1);
    send_cks(0, 0);
    @(negedge clk);
    check("recv_start_done", done, 1);
    check_writes("recv_start", n0, 2);

    // Leaving DONE drops fetch_en as RECV is entered.
    n0 = wr_addr.size();
    acc_m = 8'h00;
    pulse_start(12'd1);
    check("leave_done_fetch_en", fetch_en, 0);
    check("leave_done_busy",     busy,     1);
    check("leave_done_ready",    byte_ready, 1);
    send_prog(0, 4, 2);
    send_cks(0, 0);
    @(negedge clk);
    check("leave_done_final", done, 1);
    check_writes("leave_done", n0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
